sync_fifo_ring: RTL
===================

Name: sync_fifo_ring

Overview:
- Next-generation synchronous ring-buffer FIFO. Supports any depth (power of two not required), concurrent read and write, level reporting, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Single clock domain, for buffering byte or word streams between producer and consumer stages.

Parameters:
DEPTH, 6, number of storage entries (>= 2, any integer)
WIDTH, 8, data word width in bits
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_data  in  WIDTH  write word
wr_ready  out  1  FIFO can accept a write this cycle (= !full)
rd_en  in  1  read request (pop in FWFT mode)
rd_data  out  WIDTH  read word
rd_val  out  1  rd_data valid
level  out  $clog2(DEPTH+1)  current number of stored words
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (clk = clk, reset = reset, synchronous, active-high) sets: wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_val=0, overflow=0, underflow=0. Storage contents are not reset.
- Reset outputs: full=0, empty=1, wr_ready=1, almost_empty=1, almost_full=0 (with AF_LEVEL>0).
- Reset mid-operation discards all stored data. The first post-reset read sees an empty FIFO.
- Pointers are width $clog2(DEPTH). Increment wraps from DEPTH-1 to 0 explicitly. Modulo 2^n is not used.
- Write accept (wa) = wr_en & !full. On wa: mem[wr_ptr] <= wr_data; wr_ptr advances.
- Read accept (ra) = rd_en & !empty. On ra: rd_ptr advances.
- full/empty/level are evaluated from the registered level before the edge.
- Level update:
  - wa & !ra: +1
  - ra & !wa: -1
  - both or neither: unchanged
- Simultaneous read and write:
  - Full: read accepted, write rejected (wr_ready=0).
  - Empty: write accepted, read rejected.
  - No write-through bypass.
- wr_en while full: data dropped, overflow <= 1.
- rd_en while empty: underflow <= 1; rd_val=0 next cycle.
- Sticky flags are cleared by clr_err. If an error event occurs in the same cycle as clr_err, the set wins.
- full, empty, wr_ready, almost_full, almost_empty are combinational from the level register only. No combinational path from wr_en/rd_en to any output.
- Standard read mode (default):
  - On ra, rd_data <= mem[rd_ptr] and rd_val <= 1 at the next edge. Latency is 1 cycle.
  - rd_val is a one-cycle pulse per accepted read.
  - rd_data holds its last value when no read is accepted.
- Write-to-read visibility: a word written at edge N is readable by an rd_en sampled at edge N+1.

Optional Feature:
- Macro FIFO_FWFT_EN: first-word-fall-through mode.
  - Defined:
    - rd_val = !empty. rd_data = mem[rd_ptr], driven combinationally from registered state.
    - rd_en acts as a pop acknowledge. A pop with rd_val=0 is ignored and sets underflow.
    - Head word appears 1 cycle after it is written into an empty FIFO.
  - Undefined: standard registered read mode as above.
  - All other ports, flags and level behaviour are identical in both modes.

Test Plan:
DEPTH=6, WIDTH=8, AF_LEVEL=5, AE_LEVEL=1, standard mode unless noted.
1. Reset, then write 0x11..0x16 on 6 consecutive cycles. Expect level 1..6; almost_full at level 5; full=1 and wr_ready=0 after the 6th write. A 7th write of 0x77 sets overflow=1, level stays 6.
2. From full, read 6 times. Expect rd_val pulses with rd_data 0x11..0x16 in order, each 1 cycle after rd_en; empty=1 at end. A 7th rd_en sets underflow=1, rd_val=0, rd_data holds 0x16.
3. Wrap check: write 4, read 4, then write 0xA0..0xA5 (pointers cross DEPTH-1 to 0). Read 6 times; expect 0xA0..0xA5 in order with no corruption.
4. Simultaneous traffic: at level 3, assert wr_en and rd_en for 10 cycles with an incrementing pattern. Level stays 3 throughout; output sequence equals input sequence delayed by 3 words.
5. Boundaries: at full, assert rd_en+wr_en; expect read accepted, write dropped, overflow=1, level=5. At empty, assert both; expect write accepted, underflow=1, level=1. Assert clr_err with no event; flags clear. Assert clr_err with an empty read in the same cycle; underflow stays 1.
6. With FIFO_FWFT_EN: write 0x5A into empty FIFO. Next cycle rd_val=1 and rd_data=0x5A with no rd_en. Pop once; rd_val=0 the cycle after. Assert reset mid-stream at level 4; next cycle level=0, rd_val=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_ring.sv
// sync_fifo_ring: single-clock ring-buffer FIFO of any depth, with level reporting,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses
// registered reads with a latency of one cycle.
module sync_fifo_ring #(
    parameter int DEPTH    = 6,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_val,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wa, ra;

    assign full         = level == LW'(DEPTH);
    assign empty        = level == '0;
    assign wr_ready     = !full;
    assign almost_full  = level >= LW'(AF_LEVEL);
    assign almost_empty = level <= LW'(AE_LEVEL);
    assign wa           = wr_en & !full;
    assign ra           = rd_en & !empty;

    // storage is deliberately left unreset; only accepted writes touch it
    always_ff @(posedge clk)
        if (wa) mem[wr_ptr] <= wr_data;

    // pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wa) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (ra) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end

    // occupancy moves only when exactly one side is accepted
    always_ff @(posedge clk)
        if (reset) level <= '0;
        else level <= (wa & !ra) ? level + LW'(1) : (ra & !wa) ? level - LW'(1) : level;

    // sticky error flags; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk)
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & full) | (overflow & !clr_err);
            underflow <= (rd_en & empty) | (underflow & !clr_err);
        end

`ifdef FIFO_FWFT_EN
    assign rd_val  = !empty;
    assign rd_data = mem[rd_ptr];
`else
    // registered read port: one-cycle valid pulse, data held between reads
    always_ff @(posedge clk)
        if (reset) begin
            rd_val  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_val <= ra;
            if (ra) rd_data <= mem[rd_ptr];
        end
`endif
endmodule
